// File: rtl/rs_conv_engine_if.sv
// Handshake and tile bus between the tile loader / ofmap writer and rs_conv_engine.
// The master drives the job and o_ready. The slave (the engine) drives status and the output stream.
interface rs_conv_engine_if #(
    parameter int IFMAP  = 5,
    parameter int FILTER = 3,
    parameter int STRIDE = 1,
    parameter int DATA_W = 8,
    parameter int OUT_W  = 8
);
    localparam int OUT = (IFMAP - FILTER) / STRIDE + 1;
    localparam int CW  = (OUT > 1) ? $clog2(OUT) : 1;

    logic                             start;
    logic                             relu_en;
    logic [4:0]                       shift;
    logic [IFMAP*IFMAP*DATA_W-1:0]    ifmap_flat;
    logic [FILTER*FILTER*DATA_W-1:0]  filter_flat;
    logic                             busy;
    logic                             o_valid;
    logic                             o_ready;
    logic [OUT_W-1:0]                 o_data;
    logic [CW-1:0]                    o_row;
    logic [CW-1:0]                    o_col;
    logic                             o_last;
    logic                             done;

    modport master (
        output start, relu_en, shift, ifmap_flat, filter_flat, o_ready,
        input  busy, o_valid, o_data, o_row, o_col, o_last, done
    );

    modport slave (
        input  start, relu_en, shift, ifmap_flat, filter_flat, o_ready,
        output busy, o_valid, o_data, o_row, o_col, o_last, done
    );
endinterface

// File: rtl/rs_conv_engine.sv
// Row-stationary 2-D convolution engine: a FILTER x OUT grid of PEs, one output column per FILTER cycles.
// It captures one tile on start, computes the tile, then streams the post-processed results in raster order.
module rs_conv_engine #(
    parameter int IFMAP  = 5,
    parameter int FILTER = 3,
    parameter int STRIDE = 1,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20,
    parameter int OUT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    rs_conv_engine_if.slave  bus
);
    localparam int OUT = (IFMAP - FILTER) / STRIDE + 1;
    localparam int CW  = (OUT > 1) ? $clog2(OUT) : 1;
    localparam int TW  = (FILTER > 1) ? $clog2(FILTER) : 1;
    localparam int IW  = (IFMAP > 1) ? $clog2(IFMAP) : 1;
    localparam logic signed [ACC_W-1:0] SAT_HI = ACC_W'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [ACC_W-1:0] SAT_LO = -SAT_HI - ACC_W'(1);

    generate
        if (FILTER < 1 || STRIDE < 1 || IFMAP < FILTER || ((IFMAP - FILTER) % STRIDE) != 0)
            $error("rs_conv_engine: illegal IFMAP/FILTER/STRIDE combination");
        if (ACC_W < 2 * DATA_W + $clog2(FILTER * FILTER))
            $error("rs_conv_engine: ACC_W too narrow");
    endgenerate

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;
    state_t state_q, state_d;

    logic signed [DATA_W-1:0] ifm_q  [IFMAP][IFMAP];
    logic signed [DATA_W-1:0] flt_q  [FILTER][FILTER];
    logic signed [ACC_W-1:0]  psum_q [FILTER][OUT];
    logic signed [OUT_W-1:0]  res_q  [OUT][OUT];
    logic                     relu_q;
    logic [4:0]               shift_q;
    logic [CW-1:0]            col_q, drow_q, dcol_q;
    logic [TW-1:0]            tap_q;

    logic signed [ACC_W-1:0]  prod    [FILTER][OUT];
    logic signed [ACC_W-1:0]  col_sum [OUT];
    logic                     tap_last, col_last, beat_last, xfer;

    function automatic logic signed [OUT_W-1:0] post_proc(input logic signed [ACC_W-1:0] a,
                                                          input logic relu, input logic [4:0] sh);
        logic signed [ACC_W-1:0] v;
        v = (relu && a < 0) ? '0 : a;
        v = v >>> sh;
        if (v > SAT_HI) return OUT_W'(SAT_HI);
        if (v < SAT_LO) return OUT_W'(SAT_LO);
        return OUT_W'(v);
    endfunction

    // PE(i,j): filter row i against ifmap row j*STRIDE+i at the current column/tap.
    always_comb begin
        for (int i = 0; i < FILTER; i++) begin
            for (int j = 0; j < OUT; j++) begin
                prod[i][j] = ACC_W'(flt_q[i][tap_q] *
                    ifm_q[IW'(j * STRIDE + i)][IW'(int'(col_q) * STRIDE + int'(tap_q))]);
            end
        end
        for (int j = 0; j < OUT; j++) begin
            col_sum[j] = '0;
            for (int i = 0; i < FILTER; i++) begin
                col_sum[j] = col_sum[j] + psum_q[i][j] + prod[i][j];
            end
        end
    end

    assign tap_last  = (tap_q == TW'(FILTER - 1));
    assign col_last  = (col_q == CW'(OUT - 1));
    assign beat_last = (drow_q == CW'(OUT - 1)) && (dcol_q == CW'(OUT - 1));
    assign xfer      = (state_q == S_DRAIN) && bus.o_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (bus.start) state_d = S_LOAD;
            S_LOAD:    state_d = S_COMPUTE;
            S_COMPUTE: if (tap_last && col_last) state_d = S_DRAIN;
            S_DRAIN:   if (xfer && beat_last) state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    assign bus.busy    = (state_q == S_LOAD) || (state_q == S_COMPUTE) || (state_q == S_DRAIN);
    assign bus.o_valid = (state_q == S_DRAIN);
    assign bus.o_data  = (state_q == S_DRAIN) ? res_q[drow_q][dcol_q] : '0;
    assign bus.o_row   = drow_q;
    assign bus.o_col   = dcol_q;
    assign bus.o_last  = (state_q == S_DRAIN) && beat_last;
    assign bus.done    = (state_q == S_DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            relu_q  <= 1'b0;
            shift_q <= '0;
            col_q   <= '0;
            tap_q   <= '0;
            drow_q  <= '0;
            dcol_q  <= '0;
            for (int r = 0; r < IFMAP; r++)
                for (int c = 0; c < IFMAP; c++) ifm_q[r][c] <= '0;
            for (int r = 0; r < FILTER; r++)
                for (int c = 0; c < FILTER; c++) flt_q[r][c] <= '0;
            for (int i = 0; i < FILTER; i++)
                for (int j = 0; j < OUT; j++) psum_q[i][j] <= '0;
            for (int r = 0; r < OUT; r++)
                for (int c = 0; c < OUT; c++) res_q[r][c] <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: if (bus.start) begin
                    relu_q  <= bus.relu_en;
                    shift_q <= bus.shift;
                    for (int r = 0; r < IFMAP; r++)
                        for (int c = 0; c < IFMAP; c++)
                            ifm_q[r][c] <= bus.ifmap_flat[(r * IFMAP + c) * DATA_W +: DATA_W];
                    for (int r = 0; r < FILTER; r++)
                        for (int c = 0; c < FILTER; c++)
                            flt_q[r][c] <= bus.filter_flat[(r * FILTER + c) * DATA_W +: DATA_W];
                end
                S_LOAD: begin
                    col_q <= '0;
                    tap_q <= '0;
                    for (int i = 0; i < FILTER; i++)
                        for (int j = 0; j < OUT; j++) psum_q[i][j] <= '0;
                end
                S_COMPUTE: begin
                    if (tap_last) begin
                        tap_q <= '0;
                        col_q <= col_last ? '0 : col_q + CW'(1);
                        for (int j = 0; j < OUT; j++) begin
                            res_q[j][col_q] <= post_proc(col_sum[j], relu_q, shift_q);
                            for (int i = 0; i < FILTER; i++) psum_q[i][j] <= '0;
                        end
                    end else begin
                        tap_q <= tap_q + TW'(1);
                        for (int i = 0; i < FILTER; i++)
                            for (int j = 0; j < OUT; j++) psum_q[i][j] <= psum_q[i][j] + prod[i][j];
                    end
                end
                S_DRAIN: if (xfer) begin
                    if (dcol_q == CW'(OUT - 1)) begin
                        dcol_q <= '0;
                        drow_q <= beat_last ? '0 : drow_q + CW'(1);
                    end else begin
                        dcol_q <= dcol_q + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rs_conv_engine.sv
// Directed scoreboard bench for rs_conv_engine: 5x5/S1, 7x7/S2 and 3x3 (single-output) instances.
module tb_rs_conv_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct { int d; int r; int c; bit l; } beat_t;
    beat_t qa[$];
    beat_t qb[$];

    int im [7][7];
    int fl [3][3];
    int t2_exp [9] = '{6, 7, 8, 11, 12, 13, 16, 17, 18};
    int t5_exp [9] = '{8, 10, 12, 22, 24, 26, 36, 38, 40};

    rs_conv_engine_if #(.IFMAP(5), .FILTER(3), .STRIDE(1), .DATA_W(8), .OUT_W(8)) ifa ();
    rs_conv_engine_if #(.IFMAP(7), .FILTER(3), .STRIDE(2), .DATA_W(8), .OUT_W(8)) ifb ();
    rs_conv_engine_if #(.IFMAP(3), .FILTER(3), .STRIDE(1), .DATA_W(8), .OUT_W(8)) ifc ();

    rs_conv_engine #(.IFMAP(5), .FILTER(3), .STRIDE(1), .DATA_W(8), .ACC_W(20), .OUT_W(8))
        ua (.clk(clk), .rst(rst), .bus(ifa));
    rs_conv_engine #(.IFMAP(7), .FILTER(3), .STRIDE(2), .DATA_W(8), .ACC_W(20), .OUT_W(8))
        ub (.clk(clk), .rst(rst), .bus(ifb));
    rs_conv_engine #(.IFMAP(3), .FILTER(3), .STRIDE(1), .DATA_W(8), .ACC_W(20), .OUT_W(8))
        uc (.clk(clk), .rst(rst), .bus(ifc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pack_a();
        for (int r = 0; r < 5; r++)
            for (int c = 0; c < 5; c++) ifa.ifmap_flat[(r*5+c)*8 +: 8] = 8'(im[r][c]);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) ifa.filter_flat[(r*3+c)*8 +: 8] = 8'(fl[r][c]);
    endtask

    task automatic set_im(input int mode, input int n);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) im[r][c] = (mode == 0) ? 1 : (mode == 1) ? n*r + c : 127;
    endtask

    task automatic set_fl(input int mode);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                fl[r][c] = (mode == 0) ? 1 : (mode == 1) ? ((r == 1 && c == 1) ? 1 : 0) :
                           (mode == 2) ? -1 : 127;
    endtask

    // Reference: direct convolution with ReLU, arithmetic shift and saturation.
    task automatic model(input int sz, input int st, input bit relu, input int sh, input bit to_b);
        int o;
        int acc;
        beat_t b;
        o = (sz - 3) / st + 1;
        for (int r = 0; r < o; r++) begin
            for (int c = 0; c < o; c++) begin
                acc = 0;
                for (int i = 0; i < 3; i++)
                    for (int k = 0; k < 3; k++) acc += fl[i][k] * im[r*st+i][c*st+k];
                if (relu && acc < 0) acc = 0;
                acc = acc >>> sh;
                if (acc > 127) acc = 127;
                if (acc < -128) acc = -128;
                b = '{acc, r, c, (r == o-1) && (c == o-1)};
                if (to_b) qb.push_back(b); else qa.push_back(b);
            end
        end
    endtask

    task automatic push_list(input int vals [9], input bit to_b);
        beat_t b;
        for (int n = 0; n < 9; n++) begin
            b = '{vals[n], n / 3, n % 3, n == 8};
            if (to_b) qb.push_back(b); else qa.push_back(b);
        end
    endtask

    // Output-stream checkers for the A and B engines.
    logic [12:0] held_a;
    logic        stall_a = 1'b0;
    logic        exp_done_a = 1'b0;
    logic        exp_done_b = 1'b0;

    always @(negedge clk) begin : mon_a
        beat_t e;
        logic [12:0] cur;
        cur = {ifa.o_data, ifa.o_row, ifa.o_col, ifa.o_last};
        if (rst) begin
            stall_a    = 1'b0;
            exp_done_a = 1'b0;
        end else begin
            if (ifa.done || exp_done_a) begin
                total++;
                assert (ifa.done === exp_done_a) else begin
                    bad++; $error("FAIL a_done_timing got=%b want=%b", ifa.done, exp_done_a);
                end
            end
            if (stall_a) begin
                total++;
                assert (ifa.o_valid === 1'b1 && cur === held_a) else begin
                    bad++; $error("FAIL a_stall_stable got=%h/%b want=%h/1", cur, ifa.o_valid, held_a);
                end
            end
            exp_done_a = 1'b0;
            if (ifa.o_valid && ifa.o_ready) begin
                total++;
                assert (qa.size() > 0) else begin
                    bad++; $error("FAIL a_unexpected_beat got=%h want=none", cur);
                end
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    total++;
                    assert (cur === {8'(e.d), 2'(e.r), 2'(e.c), e.l}) else begin
                        bad++; $error("FAIL a_beat got=%h want=%h", cur, {8'(e.d), 2'(e.r), 2'(e.c), e.l});
                    end
                end
                exp_done_a = ifa.o_last;
            end
            stall_a = ifa.o_valid && !ifa.o_ready;
            held_a  = cur;
        end
    end

    always @(negedge clk) begin : mon_b
        beat_t e;
        logic [12:0] cur;
        cur = {ifb.o_data, ifb.o_row, ifb.o_col, ifb.o_last};
        if (!rst) begin
            if (ifb.done || exp_done_b) begin
                total++;
                assert (ifb.done === exp_done_b) else begin
                    bad++; $error("FAIL b_done_timing got=%b want=%b", ifb.done, exp_done_b);
                end
            end
            exp_done_b = 1'b0;
            if (ifb.o_valid && ifb.o_ready) begin
                total++;
                assert (qb.size() > 0) else begin
                    bad++; $error("FAIL b_unexpected_beat got=%h want=none", cur);
                end
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    total++;
                    assert (cur === {8'(e.d), 2'(e.r), 2'(e.c), e.l}) else begin
                        bad++; $error("FAIL b_beat got=%h want=%h", cur, {8'(e.d), 2'(e.r), 2'(e.c), e.l});
                    end
                end
                exp_done_b = ifb.o_last;
            end
        end
    end

    task automatic start_a(input bit relu, input int sh, input bit rnd);
        ifa.relu_en = relu;
        ifa.shift   = 5'(sh);
        pack_a();
        ifa.o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        ifa.start   = 1'b1;
        tick();
        ifa.start   = 1'b0;
        total++;
        assert (ifa.busy === 1'b1) else begin
            bad++; $error("FAIL a_busy_after_start got=%b want=1", ifa.busy);
        end
    endtask

    // Waits for done (cycle n counted from the start cycle); optionally checks latency.
    task automatic wait_a(input bit rnd, input bit chk_lat, input string tag);
        int n;
        bit seen;
        n = 1;
        seen = 0;
        while (n < 400 && ifa.done !== 1'b1) begin
            if (chk_lat && ifa.o_valid && !seen) begin
                seen = 1;
                total++;
                assert (n == 11) else begin
                    bad++; $error("FAIL %s_first_valid got=%0d want=11", tag, n);
                end
            end
            ifa.o_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            n++;
        end
        total++;
        assert (ifa.done === 1'b1) else begin
            bad++; $error("FAIL %s_done_timeout got=%b want=1", tag, ifa.done);
        end
        if (chk_lat) begin
            total++;
            assert (n == 20) else begin
                bad++; $error("FAIL %s_done_cycle got=%0d want=20", tag, n);
            end
        end
        total++;
        assert (qa.size() == 0) else begin
            bad++; $error("FAIL %s_missing_beats got=%0d want=0", tag, qa.size());
        end
        tick();
        total++;
        assert ({ifa.busy, ifa.done, ifa.o_valid} === 3'b000) else begin
            bad++; $error("FAIL %s_idle_after got=%b want=000", tag, {ifa.busy, ifa.done, ifa.o_valid});
        end
    endtask

    initial begin
        int n;
        ifa.start = 0; ifa.relu_en = 0; ifa.shift = 0; ifa.o_ready = 1;
        ifa.ifmap_flat = '0; ifa.filter_flat = '0;
        ifb.start = 0; ifb.relu_en = 0; ifb.shift = 0; ifb.o_ready = 1;
        ifb.ifmap_flat = '0; ifb.filter_flat = '0;
        ifc.start = 0; ifc.relu_en = 0; ifc.shift = 0; ifc.o_ready = 1;
        ifc.ifmap_flat = '0; ifc.filter_flat = '0;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        total++;
        assert ({ifa.busy, ifa.o_valid, ifa.o_last, ifa.done, ifa.o_data, ifa.o_row, ifa.o_col} === '0) else begin
            bad++; $error("FAIL reset_outputs got=%b/%b/%b/%b/%h want=0", ifa.busy, ifa.o_valid,
                          ifa.o_last, ifa.done, ifa.o_data);
        end

        // T1: all ones -> nine beats of 9, latency checked.
        set_im(0, 0); set_fl(0);
        model(5, 1, 0, 0, 0);
        start_a(0, 0, 0);
        wait_a(0, 1, "t1");

        // T2: ramp with centre tap.
        set_im(1, 5); set_fl(1);
        push_list(t2_exp, 0);
        start_a(0, 0, 0);
        wait_a(0, 1, "t2");

        // T3: saturation low, ReLU, saturation high.
        set_im(2, 0); set_fl(2);
        model(5, 1, 0, 0, 0);
        start_a(0, 0, 0);
        wait_a(0, 0, "t3a");
        model(5, 1, 1, 0, 0);
        start_a(1, 0, 0);
        wait_a(0, 0, "t3b");
        set_fl(3);
        model(5, 1, 0, 7, 0);
        start_a(0, 7, 0);
        wait_a(0, 0, "t3c");

        // T4: T2 under random backpressure.
        set_im(1, 5); set_fl(1);
        push_list(t2_exp, 0);
        start_a(0, 0, 1);
        wait_a(1, 0, "t4");

        // T6: abort during COMPUTE, then a clean job with ignored restarts and input changes.
        set_im(0, 0); set_fl(0);
        start_a(0, 0, 0);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        total++;
        assert ({ifa.busy, ifa.o_valid, ifa.o_last, ifa.done, ifa.o_data} === '0) else begin
            bad++; $error("FAIL t6_abort_reset got=%b/%b/%b/%b/%h want=0", ifa.busy, ifa.o_valid,
                          ifa.o_last, ifa.done, ifa.o_data);
        end
        repeat (20) tick();
        set_im(1, 5); set_fl(1);
        push_list(t2_exp, 0);
        start_a(0, 0, 0);
        tick();
        set_im(0, 0); set_fl(0);
        pack_a();
        ifa.start = 1'b1;
        repeat (2) tick();
        ifa.start = 1'b0;
        wait_a(0, 0, "t6");

        // T5: 7x7 tile, stride 2.
        set_im(1, 7); set_fl(1);
        push_list(t5_exp, 1);
        for (int r = 0; r < 7; r++)
            for (int c = 0; c < 7; c++) ifb.ifmap_flat[(r*7+c)*8 +: 8] = 8'(im[r][c]);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) ifb.filter_flat[(r*3+c)*8 +: 8] = 8'(fl[r][c]);
        ifb.start = 1'b1;
        tick();
        ifb.start = 1'b0;
        n = 0;
        while (n < 200 && ifb.done !== 1'b1) begin
            tick();
            n++;
        end
        total++;
        assert (ifb.done === 1'b1 && qb.size() == 0) else begin
            bad++; $error("FAIL t5_completion got=%b/%0d want=1/0", ifb.done, qb.size());
        end

        // FILTER == IFMAP: single beat flagged last.
        set_im(1, 5); set_fl(1);
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                ifc.ifmap_flat[(r*3+c)*8 +: 8]  = 8'(im[r][c]);
                ifc.filter_flat[(r*3+c)*8 +: 8] = 8'(fl[r][c]);
            end
        ifc.o_ready = 1'b0;
        ifc.start = 1'b1;
        tick();
        ifc.start = 1'b0;
        n = 1;
        while (n < 50 && ifc.o_valid !== 1'b1) begin
            tick();
            n++;
        end
        total++;
        assert (n == 5 && {ifc.o_data, ifc.o_row, ifc.o_col, ifc.o_last} === {8'd6, 1'b0, 1'b0, 1'b1}) else begin
            bad++; $error("FAIL single_beat got=%0d/%h/%b want=5/06/1", n, ifc.o_data, ifc.o_last);
        end
        ifc.o_ready = 1'b1;
        tick();
        total++;
        assert ({ifc.done, ifc.o_valid} === 2'b10) else begin
            bad++; $error("FAIL single_done got=%b want=10", {ifc.done, ifc.o_valid});
        end
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
